amux_bus_switch_seq: RTL and testbench

- Break-before-make sequencer driving the per-pad analog switch enables that connect pad nodes onto the shared AMUXBUS_A / AMUXBUS_B analog buses.
- Sits directly upstream of the pad ring's analog-mux taps, and is driven by housekeeping/CSR logic through a valid/ready request port.
- Enforces two rules: at most one pad per bus, and no pad on both buses at once.
- Inserts settle delays so that two pads are never shorted during a transition.

---
 rtl/amux_seq_pkg.sv | 24 ++
 rtl/amux_settle_timer.sv | 29 ++
 rtl/amux_bus_switch_seq.sv | 197 +++++++++++++++++++
 tb/tb_amux_bus_switch_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/amux_seq_pkg.sv
// Shared types and constants for the analog-bus break-before-make sequencer.
package amux_seq_pkg;

  localparam int unsigned CNT_W = 8;

  localparam logic BUS_A = 1'b0;
  localparam logic BUS_B = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StBreak,
    StMake,
    StFin
  } seq_state_e;

  typedef enum logic [2:0] {
    ClsErr,
    ClsNop,
    ClsMakeOnly,
    ClsSwap,
    ClsDisc
  } req_class_e;

endpackage

// File: rtl/amux_settle_timer.sv
// Loadable down-counter timing the BREAK and MAKE settle windows.
module amux_settle_timer
  import amux_seq_pkg::*;
(
  input  logic             clk,
  input  logic             resetb,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Loaded with N on entry, so the final cycle of an N-cycle window sees 1.
  assign expire = (cnt_q == CNT_W'(1));
  assign value  = cnt_q;

endmodule

// File: rtl/amux_bus_switch_seq.sv
// Break-before-make sequencer for per-pad AMUXBUS_A/AMUXBUS_B switch enables.
module amux_bus_switch_seq
  import amux_seq_pkg::*;
#(
  parameter int unsigned NUM_PADS     = 8,
  parameter int unsigned SEL_W        = 3,
  parameter int unsigned BREAK_CYCLES = 4,
  parameter int unsigned MAKE_CYCLES  = 4
) (
  input  logic                clk,
  input  logic                resetb,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_bus,
  input  logic [SEL_W-1:0]    req_pad,
  input  logic                req_connect,
  input  logic                disable_all,
  output logic [NUM_PADS-1:0] amux_a_en,
  output logic [NUM_PADS-1:0] amux_b_en,
  output logic                busy,
  output logic                done,
  output logic                err
);

  seq_state_e state_q, state_d;
  req_class_e cls, cls_q, cls_d;

  logic [NUM_PADS-1:0] a_en_q, a_en_d, b_en_q, b_en_d;
  logic [NUM_PADS-1:0] pad_oh, pad_oh_q, pad_oh_d;
  logic [NUM_PADS-1:0] tgt_vec, oth_vec, upd_vec;
  logic                bus_q, bus_d, upd, upd_bus;
  logic                done_q, done_d, err_q, err_d, busy_q;
  logic                pad_ok, accept;

  logic             timer_load, timer_expire;
  logic [CNT_W-1:0] timer_load_val, timer_value;
  logic             unused_timer_value;

  assign req_ready = resetb & (state_q == StIdle) & ~disable_all;
  assign accept    = req_valid & req_ready;

  always_comb begin
    pad_oh = '0;
    for (int i = 0; i < NUM_PADS; i++) begin
      if (int'(req_pad) == i) pad_oh[i] = 1'b1;
    end
  end

  assign pad_ok  = |pad_oh;
  assign tgt_vec = (req_bus == BUS_B) ? b_en_q : a_en_q;
  assign oth_vec = (req_bus == BUS_B) ? a_en_q : b_en_q;

  always_comb begin
    cls = ClsErr;
    if (!pad_ok) begin
      cls = ClsErr;
    end else if (req_connect) begin
      if (|(oth_vec & pad_oh))      cls = ClsErr;
      else if (|(tgt_vec & pad_oh)) cls = ClsNop;
      else if (tgt_vec == '0)       cls = ClsMakeOnly;
      else                          cls = ClsSwap;
    end else if (|(tgt_vec & pad_oh)) begin
      cls = ClsDisc;
    end
  end

  // One counter serves both windows; a swap reloads it on the BREAK->MAKE hand-off.
  assign timer_load = (state_q == StIdle && accept &&
                       (cls == ClsMakeOnly || cls == ClsSwap || cls == ClsDisc)) ||
                      (state_q == StBreak && timer_expire && cls_q == ClsSwap);
  assign timer_load_val = (state_q == StBreak || cls == ClsMakeOnly) ?
                          CNT_W'(MAKE_CYCLES) : CNT_W'(BREAK_CYCLES);

  amux_settle_timer u_timer (
    .clk      (clk),
    .resetb   (resetb),
    .load     (timer_load),
    .load_val (timer_load_val),
    .value    (timer_value),
    .expire   (timer_expire)
  );

  assign unused_timer_value = ^timer_value;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (cls)
            ClsErr, ClsNop:   state_d = StFin;
            ClsMakeOnly:      state_d = StMake;
            ClsSwap, ClsDisc: state_d = StBreak;
            default:          state_d = StFin;
          endcase
        end
      end
      StBreak: if (timer_expire) state_d = (cls_q == ClsSwap) ? StMake : StFin;
      StMake:  if (timer_expire) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (disable_all) state_d = StIdle;
  end

  always_comb begin
    a_en_d   = a_en_q;
    b_en_d   = b_en_q;
    pad_oh_d = pad_oh_q;
    bus_d    = bus_q;
    cls_d    = cls_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    upd      = 1'b0;
    upd_bus  = bus_q;
    upd_vec  = '0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          bus_d    = req_bus;
          pad_oh_d = pad_oh;
          cls_d    = cls;
          upd_bus  = req_bus;
          unique case (cls)
            ClsErr: begin
              done_d = 1'b1;
              err_d  = 1'b1;
            end
            ClsNop:           done_d = 1'b1;
            ClsMakeOnly: begin
              upd     = 1'b1;
              upd_vec = pad_oh;
            end
            ClsSwap, ClsDisc: upd = 1'b1;
            default:          done_d = 1'b1;
          endcase
        end
      end
      StBreak: begin
        if (timer_expire) begin
          if (cls_q == ClsSwap) begin
            upd     = 1'b1;
            upd_vec = pad_oh_q;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StMake:  if (timer_expire) done_d = 1'b1;
      default: ;
    endcase
    if (upd) begin
      if (upd_bus == BUS_A) a_en_d = upd_vec;
      else                  b_en_d = upd_vec;
    end
    if (disable_all) begin
      a_en_d = '0;
      b_en_d = '0;
      done_d = (state_q == StBreak) || (state_q == StMake);
      err_d  = done_d;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      a_en_q   <= '0;
      b_en_q   <= '0;
      pad_oh_q <= '0;
      bus_q    <= BUS_A;
      cls_q    <= ClsErr;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      a_en_q   <= a_en_d;
      b_en_q   <= b_en_d;
      pad_oh_q <= pad_oh_d;
      bus_q    <= bus_d;
      cls_q    <= cls_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= (state_d != StIdle);
    end
  end

  assign amux_a_en = a_en_q;
  assign amux_b_en = b_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_amux_bus_switch_seq.sv
// Scoreboard bench: driver models bus occupancy per pad, monitor checks each done pulse.
module tb_amux_bus_switch_seq;

  localparam int NP = 8;
  localparam int SW = 4;
  localparam int BC = 4;
  localparam int MC = 4;

  logic          clk = 1'b0;
  logic          resetb = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_bus = 1'b0;
  logic [SW-1:0] req_pad = '0;
  logic          req_connect = 1'b0;
  logic          disable_all = 1'b0;
  logic [NP-1:0] amux_a_en, amux_b_en;
  logic          busy, done, err;

  always #5 clk = ~clk;

  amux_bus_switch_seq #(
    .NUM_PADS     (NP),
    .SEL_W        (SW),
    .BREAK_CYCLES (BC),
    .MAKE_CYCLES  (MC)
  ) dut (
    .clk         (clk),
    .resetb      (resetb),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_bus     (req_bus),
    .req_pad     (req_pad),
    .req_connect (req_connect),
    .disable_all (disable_all),
    .amux_a_en   (amux_a_en),
    .amux_b_en   (amux_b_en),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  typedef struct {
    int          done_cyc;
    bit          err;
    logic [NP-1:0] a;
    logic [NP-1:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   on_a = -1;  // pad index on bus A, -1 when empty
  int   on_b = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [NP-1:0] vec(input int p);
    logic [NP-1:0] v;
    v = '0;
    if (p >= 0) v[p] = 1'b1;
    return v;
  endfunction

  // Monitor: bus invariants every cycle, scoreboard pop on each done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (resetb) begin
      check("a_onehot", 32'($countones(amux_a_en) <= 1), 1);
      check("b_onehot", 32'($countones(amux_b_en) <= 1), 1);
      check("pad_overlap", 32'(amux_a_en & amux_b_en), 0);
      if (done) begin
        check("done_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("done_cycle", cyc, e.done_cyc);
          check("done_err", 32'(err), 32'(e.err));
          check("done_a_en", 32'(amux_a_en), 32'(e.a));
          check("done_b_en", 32'(amux_b_en), 32'(e.b));
        end
      end
    end
  end

  task automatic send(input bit bus, input int pad, input bit conn,
                      input int abort_k, input int reset_k);
    int tgt, oth, lat, c0, last, busy_until, w;
    bit is_err, is_swap, aborted;
    logic [NP-1:0] oa, ob, fa, fb, ea, eb;
    exp_t e;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 64) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait", 32'(req_ready), 1);
    if (!req_ready) return;

    oa = vec(on_a);
    ob = vec(on_b);
    tgt = bus ? on_b : on_a;
    oth = bus ? on_a : on_b;
    is_err = 1'b0;
    is_swap = 1'b0;
    lat = 1;
    if (pad >= NP) begin
      is_err = 1'b1;
    end else if (conn) begin
      if (oth == pad)      is_err = 1'b1;
      else if (tgt == pad) lat = 1;
      else if (tgt < 0)    lat = 1 + MC;
      else begin
        lat = 1 + BC + MC;
        is_swap = 1'b1;
      end
      if (!is_err) tgt = pad;
    end else if (tgt == pad) begin
      lat = 1 + BC;
      tgt = -1;
    end else begin
      is_err = 1'b1;
    end
    if (bus) on_b = tgt;
    else     on_a = tgt;
    fa = vec(on_a);
    fb = vec(on_b);

    req_valid = 1'b1;
    req_bus = bus;
    req_pad = SW'(pad);
    req_connect = conn;
    @(posedge clk);
    #1;
    c0 = cyc;
    req_valid = 1'b0;
    req_bus = 1'($urandom);
    req_pad = SW'($urandom);
    req_connect = 1'($urandom);

    aborted = (abort_k > 0) && (lat > 1);
    busy_until = lat;
    last = lat + 1;
    if (aborted) begin
      busy_until = abort_k;
      last = abort_k + 3;
      on_a = -1;
      on_b = -1;
      e = '{done_cyc: c0 + abort_k, err: 1'b1, a: '0, b: '0};
    end else begin
      e = '{done_cyc: c0 + lat - 1, err: is_err, a: fa, b: fb};
    end
    exp_q.push_back(e);

    for (int j = 1; j <= last; j++) begin
      @(negedge clk);
      if (j == reset_k) begin
        #2 resetb = 1'b0;
        exp_q.delete();
        on_a = -1;
        on_b = -1;
        #1;
        check("rst_a_en", 32'(amux_a_en), 0);
        check("rst_b_en", 32'(amux_b_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ready", 32'(req_ready), 0);
        @(negedge clk);
        resetb = 1'b1;
        return;
      end
      if (aborted && j > abort_k) begin
        ea = '0;
        eb = '0;
      end else if (is_swap && j <= BC) begin
        ea = bus ? oa : '0;
        eb = bus ? '0 : ob;
      end else begin
        ea = fa;
        eb = fb;
      end
      check("step_a_en", 32'(amux_a_en), 32'(ea));
      check("step_b_en", 32'(amux_b_en), 32'(eb));
      check("step_busy", 32'(busy), 32'(j <= busy_until));
      if (aborted) begin
        if (j > abort_k && j < abort_k + 3) check("ready_in_disable", 32'(req_ready), 0);
        if (j == abort_k) disable_all = 1'b1;
        if (j == abort_k + 3) begin
          disable_all = 1'b0;
          #1 check("ready_after_disable", 32'(req_ready), 1);
        end
      end
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    bit b;
    int occ, p;
    bit c;
    repeat (2) @(negedge clk);
    check("reset_a_en", 32'(amux_a_en), 0);
    check("reset_b_en", 32'(amux_b_en), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_err", 32'(err), 0);
    check("reset_ready", 32'(req_ready), 0);
    resetb = 1'b1;
    #1 check("ready_after_reset", 32'(req_ready), 1);

    send(1'b0, 2, 1'b1, 0, 0);  // make-only on A
    send(1'b0, 5, 1'b1, 0, 0);  // swap on A
    send(1'b1, 5, 1'b1, 0, 0);  // pad already on A
    send(1'b1, 9, 1'b1, 0, 0);  // out-of-range pad
    send(1'b0, 5, 1'b1, 0, 0);  // already connected
    send(1'b1, 3, 1'b0, 0, 0);  // disconnect from empty bus

    for (int n = 0; n < 60; n++) begin
      b = 1'($urandom_range(0, 1));
      occ = b ? on_b : on_a;
      if (occ >= 0 && $urandom_range(0, 1) == 1) p = occ;
      else p = int'($urandom_range(0, 11));
      c = ($urandom_range(0, 9) < 7);
      send(b, p, c, 0, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    if (on_a >= 0) send(1'b0, on_a, 1'b0, 0, 0);
    if (on_b >= 0) send(1'b1, on_b, 1'b0, 0, 0);
    send(1'b0, 1, 1'b1, 0, 0);
    send(1'b1, 0, 1'b1, 0, 0);
    send(1'b0, 6, 1'b1, BC + 2, 0);  // abort during MAKE of a swap

    send(1'b1, 4, 1'b1, 0, 0);
    send(1'b1, 7, 1'b1, 0, 2);       // reset during BREAK of a swap
    send(1'b0, 3, 1'b1, 0, 0);
    send(1'b1, 3, 1'b1, 0, 0);
    send(1'b0, 3, 1'b0, 0, 0);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
